timer_counter: RTL and testbench



---
 rtl/timer_counter.sv | 156 +++++++++++++++
 tb/tb_timer_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped programmable down-counter (one bridge timer port).
//
// Register map, decoded by Addr[3:2]:
//   0 CTRL   : [0] Enable, [2:1] Mode (01 = auto-reload, else one-shot), [3] IM
//   1 PRESET : reload value, COUNT_WIDTH bits, zero-extended on read
//   2 COUNT  : current count, read-only
//   3 STATUS : only when TC_STATUS_REG_EN is defined -- [0] irq_flag,
//              [2:1] FSM state; write 1 to bit 0 clears irq_flag.
//              Otherwise reads 0 and ignores writes.
//
// IRQ is irq_flag gated by IM; both are flops, so IRQ carries no bus-side
// combinational path.

module timer_counter #(
  parameter int          COUNT_WIDTH = 32,
  parameter logic [31:0] PRESET_INIT = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;
  localparam logic [1:0] OFS_STATUS = 2'd3;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  logic [3:0]             ctrl_q,     ctrl_d;
  logic [COUNT_WIDTH-1:0] preset_q,   preset_d;
  logic [COUNT_WIDTH-1:0] count_q,    count_d;
  state_e                 state_q,    state_d;
  logic                   irq_flag_q, irq_flag_d;

  logic [1:0] addr_sel;
  logic       cfg_write;
  logic       bus_unused;

  assign addr_sel  = Addr[3:2];
  // Only CTRL and PRESET writes disturb the counting FSM.
  assign cfg_write = WE && (addr_sel == OFS_CTRL || addr_sel == OFS_PRESET);

  // The bridge has already range-qualified the address; upper bits are don't-care.
  assign bus_unused = ^{Addr[31:4], Din[31:4]};

  // Next-state logic: FSM step first, then bus writes override it.
  always_comb begin
    // NOTE: every always_comb output gets a default here so no path leaves it
    // unassigned -- an unassigned path would infer a latch.
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    state_d    = state_q;
    irq_flag_d = irq_flag_q;

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0]) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = ST_IDLE;                       // freeze COUNT where it is
        end else if (count_q > COUNT_WIDTH'(1)) begin
          count_d = count_q - COUNT_WIDTH'(1);
        end else begin
          // PRESET of 0 lands here too, so it behaves like PRESET of 1.
          count_d    = '0;
          irq_flag_d = 1'b1;
          state_d    = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_q[2:1] == MODE_RELOAD) begin
          irq_flag_d = 1'b0;                       // IDLE re-launches the count
        end else begin
          ctrl_d[0] = 1'b0;                        // one-shot: flag stays set
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef TC_STATUS_REG_EN
    // Write-1-to-clear of the flag; an expiry in the same cycle wins.
    if (WE && addr_sel == OFS_STATUS && Din[0] &&
        !(state_q == ST_CNT && ctrl_q[0] && count_q <= COUNT_WIDTH'(1))) begin
      irq_flag_d = 1'b0;
    end
`endif

    // A configuration write restarts the FSM from IDLE but leaves COUNT alone.
    if (cfg_write) begin
      state_d    = ST_IDLE;
      irq_flag_d = 1'b0;
      count_d    = count_q;
      if (addr_sel == OFS_CTRL) ctrl_d   = Din[3:0];
      else                      preset_d = Din[COUNT_WIDTH-1:0];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all flops so every register samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      ctrl_q     <= '0;
      preset_q   <= PRESET_INIT[COUNT_WIDTH-1:0];
      count_q    <= '0;
      state_q    <= ST_IDLE;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      state_q    <= state_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Read mux: purely combinational, no side-effects on read.
  always_comb begin
    Dout = '0;
    unique case (addr_sel)
      OFS_CTRL:   Dout[3:0]             = ctrl_q;
      OFS_PRESET: Dout[COUNT_WIDTH-1:0] = preset_q;
      OFS_COUNT:  Dout[COUNT_WIDTH-1:0] = count_q;
      OFS_STATUS: begin
`ifdef TC_STATUS_REG_EN
        Dout[2:0] = {state_q, irq_flag_q};
`else
        Dout = '0;
`endif
      end
      default: Dout = '0;
    endcase
  end

  assign IRQ = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter (default parameters). Inputs change and
// outputs are sampled just after the falling edge, away from the active edge.
// Edge numbering in comments: E0 is the rising edge that performs the
// CTRL write, E1 the next one, and so on.

module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:2] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_vec;
  int n_err;

  timer_counter #(
    .COUNT_WIDTH(32),
    .PRESET_INIT(32'd0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (addr),
    .WE   (we),
    .Din  (din),
    .Dout (dout),
    .IRQ  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus write; returns just after the falling edge that follows the write edge.
  task automatic wr(input logic [1:0] ofs, input logic [31:0] data);
    addr = {28'd0, ofs};
    din  = data;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
    din  = '0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] ofs, input logic [31:0] exp);
    addr = {28'd0, ofs};
    #1;
    check(tag, dout, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    check(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    we    = 1'b0;
    addr  = '0;
    din   = '0;
    tick(2);
    reset = 1'b0;
    tick(1);

    // Reset state
    chk_reg("rst_ctrl",   2'd0, 32'h0);
    chk_reg("rst_preset", 2'd1, 32'h0);
    chk_reg("rst_count",  2'd2, 32'h0);
    chk_reg("rst_rsvd",   2'd3, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // One-shot, PRESET=5: COUNT=5 after E2 ... 0 after E7, IRQ rises at E7.
    wr(2'd1, 32'd5);
    chk_reg("preset_rb", 2'd1, 32'd5);
    wr(2'd0, 32'h9);                           // E0
    tick(2);                                   // after E2
    for (int k = 0; k < 6; k++) begin
      chk_reg($sformatf("os_count_%0d", k), 2'd2, 32'(5 - k));
      chk_irq($sformatf("os_irq_%0d", k), k == 5);
      if (k < 5) tick(1);
    end
    tick(1);                                   // after E8: Enable auto-cleared
    chk_reg("os_ctrl_after", 2'd0, 32'h8);
    chk_irq("os_irq_hold_a", 1'b1);
    tick(3);
    chk_irq("os_irq_hold_b", 1'b1);
    chk_reg("os_count_hold", 2'd2, 32'd0);
`ifdef TC_STATUS_REG_EN
    chk_reg("status_set", 2'd3, 32'h1);        // flag=1, state IDLE
    wr(2'd3, 32'h1);
    chk_reg("status_clr", 2'd3, 32'h0);
    chk_irq("status_irq_drop", 1'b0);
    chk_reg("status_ctrl_kept", 2'd0, 32'h8);
`else
    chk_reg("rsvd_read_zero", 2'd3, 32'h0);
`endif

    // Auto-reload, PRESET=3: IRQ high one cycle at E5, E11, E17, E23.
    wr(2'd1, 32'd3);
    chk_irq("ar_irq_cleared", 1'b0);
    wr(2'd0, 32'hB);                           // E0
    for (int c = 1; c <= 24; c++) begin
      tick(1);
      chk_irq($sformatf("ar_irq_e%0d", c), (c >= 5) && ((c - 5) % 6 == 0));
    end
    wr(2'd0, 32'h8);

    // Freeze mid-count, then restart from PRESET.
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);                           // E0
    tick(12);                                  // after E12: COUNT=10
    chk_reg("fz_count_10", 2'd2, 32'd10);
    wr(2'd0, 32'h8);                           // bus write beats the decrement
    chk_reg("fz_count_held", 2'd2, 32'd10);
    tick(5);
    chk_reg("fz_count_still", 2'd2, 32'd10);
    chk_irq("fz_irq", 1'b0);
    wr(2'd0, 32'h9);                           // E0
    tick(1);
    chk_reg("fz_no_resume", 2'd2, 32'd10);     // IDLE->LOAD, not yet loaded
    tick(1);
    chk_reg("fz_reload", 2'd2, 32'd20);
    tick(1);
    chk_reg("fz_dec", 2'd2, 32'd19);

    // Writes to COUNT and reserved offset do not disturb the count.
    wr(2'd2, 32'h55);
    chk_reg("wr_count_ignored", 2'd2, 32'd18);
    wr(2'd3, 32'h0);
    chk_reg("wr_rsvd_ignored", 2'd2, 32'd17);
    chk_reg("wr_ctrl_intact", 2'd0, 32'h9);

    // Reset mid-count.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_reg("mid_rst_count",  2'd2, 32'd0);
    chk_reg("mid_rst_ctrl",   2'd0, 32'd0);
    chk_reg("mid_rst_preset", 2'd1, 32'd0);
    tick(3);
    chk_reg("mid_rst_stays", 2'd2, 32'd0);

    // PRESET=0 behaves as PRESET=1: IRQ at E3.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);                           // E0
    tick(2);
    chk_reg("p0_count", 2'd2, 32'd0);
    chk_irq("p0_irq_before", 1'b0);
    tick(1);
    chk_irq("p0_irq_e3", 1'b1);

    // One-shot with IM=0: no IRQ, Enable clears; CTRL write clears the flag.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);                           // E0, expiry at E4
    tick(4);
    chk_irq("im0_irq_e4", 1'b0);
    tick(1);
    chk_reg("im0_ctrl", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    chk_irq("im0_after_unmask", 1'b0);
    tick(2);
    chk_irq("im0_after_unmask_b", 1'b0);

    // Mode 2'b1x runs one-shot and reads back as written; upper CTRL bits read 0.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'hFFFF_FFFD);                   // Enable, mode 10, IM; IRQ at E3
    tick(3);
    chk_irq("m2_irq", 1'b1);
    tick(1);
    chk_reg("m2_ctrl", 2'd0, 32'hC);
    tick(8);
    chk_irq("m2_no_reload", 1'b1);
    chk_reg("m2_count", 2'd2, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
